conv_weight_bank: RTL
=====================

# conv_weight_bank

Parametrised, double-buffered convolution weight store for the streaming conv datapath. It loads `NCH` kernels of `K`×`K` weights plus one bias each from a single serial burst into a shadow bank. The shadow bank then becomes active either immediately, when nothing is active yet, or on a `swap_req` at a frame boundary. The active weights keep driving the MAC array throughout a reload.

## Interface
Parameters:
- `DW`, 16, weight/bias word width (signed fixed-point, opaque to this block)
- `K`, 3, kernel side; K*K weights per kernel
- `NCH`, 4, number of kernels (output channels) stored
- derived, not overridable: `WPK` = K*K+1 words per kernel; `TOTAL` = NCH*WPK; `CW` = clog2(NCH) (min 1); `NW` = clog2(TOTAL+2)

Ports:
- `pclk`  in  1  clock; single clock domain
- `rst_n`  in  1  reset; asynchronous, active-low
- `wr_data`  in  DW  serial load word
- `wr_en`  in  1  burst qualifier; one word per high cycle, burst = contiguous high run
- `swap_req`  in  1  level; permits commit of a pending shadow bank
- `rd_ch`  in  CW  kernel select for readout
- `weights`  out  K*K*DW  selected kernel, w(0,0) in LSBs, row-major
- `bias`  out  DW  selected kernel bias
- `weights_ready`  out  1  active bank holds a committed load
- `load_busy`  out  1  burst in progress or commit pending
- `load_err`  out  1  one-cycle pulse: burst length ≠ TOTAL

## Operation
- Burst word order: kernel 0 w(0,0)…w(K-1,K-1), bias0, kernel 1 …, bias(NCH-1).
- Storage is two banks of TOTAL words plus bit `act`. Loads always write bank `!act`.
- State machine:
  - IDLE: `wr_en`=1 → LOAD; the first word is written at address 0 and `cnt`=1.
  - LOAD: each `wr_en`=1 cycle writes address `cnt` if `cnt`<TOTAL. `cnt` increments, saturating at TOTAL+1.
  - LOAD, first `wr_en`=0 with `cnt`==TOTAL → PEND.
  - LOAD, first `wr_en`=0 with `cnt`≠TOTAL → pulse `load_err`, go to IDLE. The shadow is discarded and the active bank is untouched.
  - PEND: if `!weights_ready` or `swap_req`=1, toggle `act`, set `weights_ready`=1, go to IDLE.
  - PEND: if `wr_en`=1, drop the pending load and go to LOAD with `cnt` restarting at 0. The current word is written at address 0.
- `swap_req` is ignored outside PEND.
- `load_busy` = (state ≠ IDLE).
- `weights_ready` never falls after the first commit, except on reset. This differs from the single-kernel loader, which cleared ready on every reload.
- Readout is registered. `weights`/`bias` are all-zero while `weights_ready`=0.
- Overlong bursts: words beyond TOTAL are not stored. The saturated count guarantees the error is flagged.

## Timing
- Reset values:
  - state IDLE, `act`=0, `cnt`=0
  - `weights_ready`=0, `load_busy`=0, `load_err`=0
  - `weights`=0, `bias`=0
  - bank contents = 0
- Write latency: a word sampled at edge E is stored at E.
- Commit latency, first load: last word at edge N, `wr_en` low sampled at N+1 (→PEND), commit at N+2. `weights_ready`=1 and new data are selectable after N+2, and outputs update at N+3.
- Commit latency, reload: commit occurs at the first PEND edge with `swap_req`=1, at the earliest N+2.
- `load_err` is high for exactly the cycle after edge N+1.
- Read latency: `rd_ch`/`act` sampled at edge E → `weights`/`bias` valid after E.
- `rd_ch` ≥ NCH (non-power-of-two NCH) → outputs zero.
- Reset mid-burst or mid-PEND: everything returns to reset values, including `weights_ready`=0.

## Structure
- Shared conv parameter include: `DW`, `K` defaults, and a clog2 function reused by line buffers and the MAC array.
- One sub-module, `weight_bank_regs`: a single TOTAL×DW register bank with an address write port and a K*K+1-word channel read port. It is instantiated twice. The top level holds the FSM, `cnt`, `act`, and the output registers.

## Test plan
- Reset, no load, K=3, NCH=4 (TOTAL=40) → `weights_ready`=0, `weights`=0, `bias`=0, `load_busy`=0.
- 40-word burst with values 1..40 → `weights_ready` rises 2 edges after the last word. With `rd_ch`=2, `weights` = words 21..29 and `bias`=30.
- Second burst with values 101..140 and `swap_req`=0 held for 20 cycles → outputs stay at 21..30 and `load_busy`=1. Pulse `swap_req` → the next read of ch2 gives 121..130.
- 39-word burst → one `load_err` pulse, active data unchanged, `load_busy` returns to 0.
- 41-word burst → one `load_err` pulse, no commit.
- Burst restarted while in PEND (new 40 words) → only the newer data commits.
- `rst_n` low during word 17 → all outputs zero.
- After the mid-burst reset, a fresh 40-word load commits as a first load, with no `swap_req` needed.

Source files
------------

// File: rtl/conv_weight_bank_pkg.sv
// Shared conv-datapath parameters and helpers, reused by line buffers, the MAC array
// and the weight store.
package conv_weight_bank_pkg;

    localparam int CONV_DW = 16;
    localparam int CONV_K  = 3;

    // Ceiling log2, constant-foldable for parameter derivation.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PEND = 2'd2
    } load_state_t;

endpackage

// File: rtl/conv_weight_bank_regs.sv
// One TOTAL x DW weight bank: single address write port and a whole-kernel
// (K*K weights + bias) combinational channel read port.
module weight_bank_regs
    import conv_weight_bank_pkg::*;
#(
    parameter int  DW    = CONV_DW,
    parameter int  K     = CONV_K,
    parameter int  NCH   = 4,
    localparam int WPK   = K * K + 1,
    localparam int TOTAL = NCH * WPK,
    localparam int AW    = (clog2(TOTAL) < 1) ? 1 : clog2(TOTAL),
    localparam int CW    = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DW-1:0]       wdata,
    input  logic [CW-1:0]       rd_ch,
    output logic [WPK*DW-1:0]   rd_words
);

    logic [DW-1:0] mem [TOTAL];
    logic          ch_valid;
    logic [CW-1:0] ch_safe;
    logic [AW-1:0] base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TOTAL; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(waddr) < TOTAL)) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range channels (non-power-of-two NCH) read as zero without indexing past the array.
    assign ch_valid = (32'(rd_ch) < NCH);
    assign ch_safe  = ch_valid ? rd_ch : '0;
    assign base     = AW'(32'(ch_safe) * WPK);

    genvar gi;
    generate
        for (gi = 0; gi < WPK; gi++) begin : g_rd
            assign rd_words[gi*DW +: DW] = ch_valid ? mem[base + AW'(gi)] : '0;
        end
    endgenerate

endmodule

// File: rtl/conv_weight_bank.sv
// Double-buffered conv weight store: serial burst loads the shadow bank, which is
// committed at once on the first load or on swap_req for reloads.
module conv_weight_bank
    import conv_weight_bank_pkg::*;
#(
    parameter int  DW    = CONV_DW,
    parameter int  K     = CONV_K,
    parameter int  NCH   = 4,
    localparam int WPK   = K * K + 1,
    localparam int TOTAL = NCH * WPK,
    localparam int CW    = (clog2(NCH) < 1) ? 1 : clog2(NCH),
    localparam int NW    = clog2(TOTAL + 2)
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic [DW-1:0]       wr_data,
    input  logic                wr_en,
    input  logic                swap_req,
    input  logic [CW-1:0]       rd_ch,
    output logic [K*K*DW-1:0]   weights,
    output logic [DW-1:0]       bias,
    output logic                weights_ready,
    output logic                load_busy,
    output logic                load_err
);

    localparam int AW = (clog2(TOTAL) < 1) ? 1 : clog2(TOTAL);

    load_state_t       state_reg, state_next;
    logic [NW-1:0]     cnt_reg, cnt_next;
    logic              act_reg, act_next;
    logic              ready_reg, ready_next;
    logic              err_reg, err_next;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [WPK*DW-1:0] bank_rd [2];
    logic [WPK*DW-1:0] sel_words;
    logic [K*K*DW-1:0] weights_reg;
    logic [DW-1:0]     bias_reg;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            act_reg   <= 1'b0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            act_reg   <= act_next;
            ready_reg <= ready_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        act_next   = act_reg;
        ready_next = ready_reg;
        err_next   = 1'b0;
        we         = 1'b0;
        waddr      = '0;
        case (state_reg)
            ST_IDLE: begin
                if (wr_en) begin
                    we         = 1'b1;
                    cnt_next   = NW'(1);
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (wr_en) begin
                    we    = (cnt_reg < NW'(TOTAL));
                    waddr = cnt_reg[AW-1:0];
                    // Saturating at TOTAL+1 keeps any overlong burst distinguishable from a good one.
                    if (cnt_reg != NW'(TOTAL + 1)) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_next = '0;
                    if (cnt_reg == NW'(TOTAL)) begin
                        state_next = ST_PEND;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_PEND: begin
                // Commit wins over a coincident restart; that word is not stored.
                if (!ready_reg || swap_req) begin
                    act_next   = ~act_reg;
                    ready_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (wr_en) begin
                    we         = 1'b1;
                    cnt_next   = NW'(1);
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            weight_bank_regs #(
                .DW  (DW),
                .K   (K),
                .NCH (NCH)
            ) u_bank (
                .clk      (pclk),
                .rst_n    (rst_n),
                .we       (we && (act_reg != 1'(gi))),
                .waddr    (waddr),
                .wdata    (wr_data),
                .rd_ch    (rd_ch),
                .rd_words (bank_rd[gi])
            );
        end
    endgenerate

    assign sel_words = act_reg ? bank_rd[1] : bank_rd[0];

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            weights_reg <= '0;
            bias_reg    <= '0;
        end else if (ready_reg) begin
            weights_reg <= sel_words[K*K*DW-1:0];
            bias_reg    <= sel_words[WPK*DW-1 -: DW];
        end else begin
            weights_reg <= '0;
            bias_reg    <= '0;
        end
    end

    assign weights       = weights_reg;
    assign bias          = bias_reg;
    assign weights_ready = ready_reg;
    assign load_busy     = (state_reg != ST_IDLE);
    assign load_err      = err_reg;

endmodule
